// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin arbiter sharing one enable/done multiplier between NREQ requesters.
// One operation is in flight at a time; a watchdog aborts operations whose done never arrives.
module karatsuba_mul_arbiter #(
    parameter int WIDTH   = 128,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_ab,
    output logic                      rsp_err,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    output logic                      mul_enable,
    input  logic [2*WIDTH-1:0]        mul_ab,
    input  logic                      mul_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDW-1:0]   rr_r;
    logic [IDW-1:0]   rr_next_s;
    logic [CW-1:0]    cnt_r;
    logic [IDW-1:0]   grant_s;
    logic             grant_vld_s;
    logic             accept_s;
    logic             fin_done_s;
    logic             fin_tmo_s;
    logic [WIDTH-1:0] lane_a_s [NREQ];
    logic [WIDTH-1:0] lane_b_s [NREQ];

    // Unpack the flat operand buses into per-requester lanes.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane_a_s[i] = req_a[i*WIDTH +: WIDTH];
            lane_b_s[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search from rr_r upward; walking k downward lets the nearest valid requester win.
    always_comb begin
        logic [IDW:0] sum_v;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_v = {1'b0, rr_r} + (IDW+1)'(k);
            sum_v = (sum_v >= (IDW+1)'(NREQ)) ? (sum_v - (IDW+1)'(NREQ)) : sum_v;
            grant_s     = req_valid[sum_v[IDW-1:0]] ? sum_v[IDW-1:0] : grant_s;
            grant_vld_s = grant_vld_s | req_valid[sum_v[IDW-1:0]];
        end
    end

    assign accept_s   = (state_r == ST_IDLE) && grant_vld_s;
    assign fin_done_s = (state_r == ST_RUN) && mul_done;
    assign fin_tmo_s  = (state_r == ST_RUN) && !mul_done && (cnt_r == CW'(TIMEOUT));

    // Pointer for the next search: one past the granted requester, with wrap.
    always_comb begin
        if (grant_s == IDW'(NREQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_s + IDW'(1);
        end
    end

    // Accept is offered only in IDLE, one-hot at the granted requester.
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic; a done on the timeout edge takes priority over the abort.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (fin_done_s || fin_tmo_s) state_s = ST_RESP;
                else                         state_s = ST_RUN;
            end
            ST_RESP: begin
                if (rsp_ready) state_s = ST_IDLE;
                else           state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and flag registers; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            rr_r        <= '0;
            cnt_r       <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_enable  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_ab      <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_r    <= state_s;
            mul_enable <= (state_s == ST_RUN);
            rsp_valid  <= (state_s == ST_RESP);
            busy       <= (state_s != ST_IDLE);
            if (accept_s) begin
                mul_a  <= lane_a_s[grant_s];
                mul_b  <= lane_b_s[grant_s];
                rsp_id <= grant_s;
                rr_r   <= rr_next_s;
            end
            // cnt_r holds the number of completed RUN cycles, so abort fires after TIMEOUT+1 enable cycles.
            if ((state_r == ST_RUN) && (state_s == ST_RUN)) begin
                cnt_r <= cnt_r + CW'(1);
            end else if (state_s == ST_IDLE) begin
                cnt_r <= '0;
            end
            if (fin_done_s) begin
                rsp_ab  <= mul_ab;
                rsp_err <= 1'b0;
            end else if (fin_tmo_s) begin
                rsp_ab      <= '0;
                rsp_err     <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/karatsuba_mul_arbiter.md
Name: karatsuba_mul_arbiter

Overview:
Shares one KaratsubaWrapper-style multiplier between NREQ requesters. The multiplier uses an enable/done interface and has multi-cycle latency.
- Each requester has a valid/ready operand port.
- Grants are round-robin; one operation is in flight at a time.
- The product is returned on a single valid/ready response port, tagged with the requester index.
- A watchdog aborts operations whose done never arrives.
- Sits between the MSM scheduler's multiply requesters and the multiplier instance.

Parameters:
WIDTH, 128, operand width; product width is 2*WIDTH.
NREQ, 4, number of requesters (2..16).
TIMEOUT, 64, max cycles from first mul_enable high to mul_done before abort (≥2).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
req_valid  in  NREQ  per-requester operand valid.
req_ready  out  NREQ  per-requester accept; one-hot or zero.
req_a  in  NREQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH].
req_b  in  NREQ*WIDTH  operand b, same packing.
rsp_valid  out  1  result valid.
rsp_ready  in  1  result consumer ready.
rsp_id  out  $clog2(NREQ)  requester index of the result.
rsp_ab  out  2*WIDTH  product (zero on timeout).
rsp_err  out  1  qualifies the current response as timed out.
mul_a  out  WIDTH  to multiplier a; registered.
mul_b  out  WIDTH  to multiplier b; registered.
mul_enable  out  1  to multiplier enable.
mul_ab  in  2*WIDTH  from multiplier product.
mul_done  in  1  from multiplier; sampled only in RUN.
busy  out  1  high in RUN or RESP.
timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (reset=0 at clock edge):
  - State goes to IDLE; rr pointer goes to 0; watchdog counter is cleared.
  - Outputs are 0: req_ready, rsp_valid, rsp_err, mul_enable, busy, timeout_err, rsp_id, rsp_ab, mul_a, mul_b.
  - Reset mid-operation abandons the operation; no response is produced. The multiplier sees mul_enable drop on the next cycle.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i], searching from the rr pointer upward with wrap.
  - req_ready is combinational: one-hot at g, zero if no request.
  - On accept (req_valid[g] & req_ready[g]) at edge T:
    - latch mul_a/mul_b from requester g;
    - latch rsp_id = g;
    - set rr pointer to (g+1) mod NREQ;
    - go to RUN.
  - mul_enable=0 in IDLE.
- RUN:
  - mul_enable=1 throughout, first high in cycle T+1. Operands are held stable.
  - Watchdog counter increments each RUN cycle, starting at 1.
  - mul_done=1 at an edge: capture rsp_ab=mul_ab, rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT with no done: rsp_ab=0, rsp_err=1, set timeout_err, go to RESP.
  - Done and timeout at the same edge: done wins.
  - req_ready=0 in RUN.
- RESP:
  - rsp_valid=1 and mul_enable=0; rsp_ab, rsp_id and rsp_err are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE and clear the counter.
  - The next accept can occur in that IDLE cycle at the earliest, giving mul_enable at least one low cycle between operations. The multiplier needs this to re-arm.
- Latency: accept at edge T, multiplier done at edge T+1+L, rsp_valid high from cycle T+2+L.
  - Best-case throughput is one op per L+3 cycles with rsp_ready tied high.
- mul_done in IDLE or RESP is ignored and has no state change.
- req_valid may drop without handshake; no request is granted unless valid in that same cycle.
- The rr pointer advances only on accept. Requesters must hold operands stable only until their accept edge.
- Starvation bound: a continuously valid requester is granted within NREQ grants.
- busy = (state != IDLE).

Test Plan:
1. Single op: multiplier model L=5; req 2 sends a=3, b=7 → req_ready[2] high the same cycle; mul_enable high for 6 cycles; rsp_valid=1 with rsp_id=2, rsp_ab=21, rsp_err=0 at T+7.
2. Fairness: all 4 requesters continuously valid, 8 ops → grant order 0,1,2,3,0,1,2,3; each product matches a*b, including a=b=2^128-1 → 2^256-2^129+1.
3. Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid → rsp fields stable, mul_enable=0, no req_ready during the stall; accept happens after rsp_ready=1.
4. Timeout: multiplier never asserts done, TIMEOUT=64 → rsp_valid at cycle T+66 with rsp_ab=0, rsp_err=1, timeout_err sticky; the next op completes normally with rsp_err=0.
5. Reset mid-op: reset=0 for 1 cycle during RUN → next cycle all outputs 0 and rr pointer 0; no response for the aborted op; a following request from 0 is granted first.
6. Spurious done: mul_done pulsed in IDLE and in RESP → no state change, rsp_ab unchanged.
